fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that drives the program counter's `absjump_en`/`target` inputs every cycle. It turns decoder requests (conditional branch, jump, call, return, halt) and pipeline stall into PC control. It owns run/idle/halt sequencing and a small return-address stack (RAS). It sits between the decoder/ALU flag logic and the PC register; the PC's own increment is the default "no action" path.

## Interface
- `D`, 10, PC/address width (matches PC).
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2).

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; shared with PC.
- `start`  in  1  begin execution from IDLE, or restart from HALT.
- `stall`  in  1  hold PC this cycle (pipeline back-pressure).
- `halt_req`  in  1  current instruction is HALT.
- `br_en`  in  1  current instruction is a conditional branch.
- `br_taken`  in  1  branch condition true (valid when `br_en`).
- `jmp_en`  in  1  unconditional absolute jump.
- `call_en`  in  1  call: push return address, jump.
- `ret_en`  in  1  return: pop address, jump.
- `br_target`  in  D  absolute target for branch/jump/call.
- `prog_ctr`  in  D  current PC value.
- `absjump_en`  out  1  to PC.
- `target`  out  D  to PC.
- `running`  out  1  state == RUN.
- `done`  out  1  state == HALT.
- `ras_ovf`  out  1  sticky: call pushed onto a full RAS.
- `ras_unf`  out  1  sticky: return on an empty RAS.

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE, RAS count 0, both sticky flags 0.
- While `reset`=1: `absjump_en`=0, `target`=0. PC reset has priority.
- IDLE: hold PC (`absjump_en`=1, `target`=`prog_ctr`). On `start` → RUN; PC still holds that cycle.
- HALT: hold PC, `done`=1. On `start`: `absjump_en`=1, `target`=0, RAS cleared, flags cleared → RUN.
- RUN, priority highest first:
  1. `stall`: hold PC. No push/pop, no state change; all other requests ignored.
  2. `halt_req`: hold PC → HALT.
  3. `ret_en`: if RAS non-empty, pop and jump to popped address. If empty, set `ras_unf`, hold PC, go to HALT.
  4. `call_en`: push `prog_ctr+1` (mod 2^D, so 2^D−1 wraps to 0) and jump to `br_target`. If full, set `ras_ovf`, drop the oldest entry (circular overwrite), count stays `RAS_DEPTH`, and the call is still taken.
  5. `jmp_en`: jump to `br_target`.
  6. `br_en && br_taken`: jump to `br_target`.
  7. Otherwise `absjump_en`=0 (PC increments).
- `br_en` with `br_taken`=0 falls through to case 7.
- Decoder requests are one-hot. If several are set together, the priority above governs; e.g. call+ret performs the ret only.
- A stall cycle has no effect; the decoder re-presents the same requests next cycle.

## Timing
- `absjump_en`/`target` are combinational from state, RAS top and inputs. The PC takes the new value at the next posedge, so redirect latency is 1 cycle.
- State, RAS pointer/count and sticky flags update at the same posedge.
- `running`/`done`/flags are registered-state outputs, valid the cycle after the transition.
- A push followed by a pop in consecutive cycles returns the just-pushed value; there is no bypass hazard.
- `reset` mid-RUN: the next cycle is IDLE, the RAS is emptied, and any in-flight pop/push is discarded.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum {IDLE, RUN, HALT}; `fetch_act_t` enum {ACT_INC, ACT_HOLD, ACT_JUMP, ACT_RET, ACT_ZERO} used by the priority decode.
- Sub-module `ret_addr_stack` (params `D`, `RAS_DEPTH`): circular storage, top pointer, count.
  - Inputs: `push`, `pop`, `clr`, `din`.
  - Outputs: `top`, `empty`, `full`.
  - Overwrite-oldest on full push.
- The top level holds the FSM and the priority mux.

## Test plan
- Reset, then `start`; no requests for 5 cycles → PC sequence 0,0,1,2,3,4; `running`=1 from cycle 2.
- At PC=3, `br_en`=1, `br_taken`=1, `br_target`=0x80 → next PC 0x80. Repeat with `br_taken`=0 → next PC 4.
- Call at PC=10 to 0x100, call at 0x102 to 0x200, then ret, then ret → PC 0x100, 0x102, 0x200, 0x103, 11.
- Five nested calls with `RAS_DEPTH`=4 → `ras_ovf`=1. Four rets return the addresses of calls 5, 4, 3, 2. A fifth ret → `ras_unf`=1, `done`=1, PC frozen.
- `stall`=1 together with `call_en`=1 at PC=7 → PC stays 7, RAS count unchanged. Next cycle with the stall dropped → call performed.
- `halt_req` at PC=20 → PC holds 20, `done`=1. Then `start` → PC=0, flags cleared, `running`=1. Separately, `reset` mid-RUN → IDLE and RAS empty.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and the
// PC-control action chosen by the priority decode.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        ACT_INC  = 3'd0,
        ACT_HOLD = 3'd1,
        ACT_JUMP = 3'd2,
        ACT_RET  = 3'd3,
        ACT_ZERO = 3'd4
    } fetch_act_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack; a push onto a full stack silently
// overwrites the oldest entry while the count saturates at RAS_DEPTH.
module ret_addr_stack
    import fetch_pkg::*;
#(
    parameter int D         = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clr,
    input  logic [D-1:0] din,
    output logic [D-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(RAS_DEPTH);

    logic [D-1:0]  mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_inc;
    logic [PW:0]   count;

    assign ptr_inc = ptr + 1'b1;

    // NOTE: the storage array has no reset; count gates validity, so stale
    // entries are never read as meaningful data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_inc] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr_inc;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    assign top   = mem[ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: IDLE/RUN/HALT sequencing plus the priority decode that
// turns decoder requests into the PC's absjump_en/target controls.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int D         = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         halt_req,
    input  logic         br_en,
    input  logic         br_taken,
    input  logic         jmp_en,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [D-1:0] br_target,
    input  logic [D-1:0] prog_ctr,
    output logic         absjump_en,
    output logic [D-1:0] target,
    output logic         running,
    output logic         done,
    output logic         ras_ovf,
    output logic         ras_unf
);

    fetch_state_t state, state_next;
    fetch_act_t   act;
    logic         push, pop, clr, set_ovf, set_unf;
    logic         ras_empty, ras_full;
    logic [D-1:0] ras_top, ret_addr;

    // Return address wraps modulo 2^D, matching the PC's own increment.
    assign ret_addr = prog_ctr + 1'b1;

    ret_addr_stack #(.D(D), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (ret_addr),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        act        = ACT_HOLD;
        push       = 1'b0;
        pop        = 1'b0;
        clr        = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            HALT: begin
                if (start) begin
                    act        = ACT_ZERO;
                    clr        = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stall) begin
                    act = ACT_HOLD;
                end else if (halt_req) begin
                    state_next = HALT;
                end else if (ret_en) begin
                    if (!ras_empty) begin
                        act = ACT_RET;
                        pop = 1'b1;
                    end else begin
                        set_unf    = 1'b1;
                        state_next = HALT;
                    end
                end else if (call_en) begin
                    act     = ACT_JUMP;
                    push    = 1'b1;
                    set_ovf = ras_full;
                end else if (jmp_en || (br_en && br_taken)) begin
                    act = ACT_JUMP;
                end else begin
                    act = ACT_INC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // PC reset has priority, so the redirect is suppressed while reset is high.
    always_comb begin
        absjump_en = 1'b1;
        target     = prog_ctr;
        if (reset) begin
            absjump_en = 1'b0;
            target     = '0;
        end else begin
            case (act)
                ACT_INC:  begin absjump_en = 1'b0; target = '0; end
                ACT_JUMP: target = br_target;
                ACT_RET:  target = ras_top;
                ACT_ZERO: target = '0;
                default:  target = prog_ctr;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            state <= state_next;
            if (clr) begin
                ras_ovf <= 1'b0;
                ras_unf <= 1'b0;
            end else begin
                if (set_ovf) ras_ovf <= 1'b1;
                if (set_unf) ras_unf <= 1'b1;
            end
        end
    end

    assign running = (state == RUN);
    assign done    = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a PC register follows absjump_en/target, and the
// expected next PC for each driven cycle is queued and compared after the edge.
module tb_fetch_sequencer;

    localparam int D = 10;

    localparam logic [7:0] F_START = 8'h80;
    localparam logic [7:0] F_STALL = 8'h40;
    localparam logic [7:0] F_HALT  = 8'h20;
    localparam logic [7:0] F_BR    = 8'h10;
    localparam logic [7:0] F_TAKEN = 8'h08;
    localparam logic [7:0] F_JMP   = 8'h04;
    localparam logic [7:0] F_CALL  = 8'h02;
    localparam logic [7:0] F_RET   = 8'h01;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, stall, halt_req, br_en, br_taken, jmp_en, call_en, ret_en;
    logic [D-1:0] br_target;
    logic [D-1:0] pc;
    logic         absjump_en;
    logic [D-1:0] target;
    logic         running, done, ras_ovf, ras_unf;

    int checks = 0;
    int errors = 0;
    logic [D-1:0] exp_q[$];

    fetch_sequencer #(.D(D), .RAS_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .halt_req   (halt_req),
        .br_en      (br_en),
        .br_taken   (br_taken),
        .jmp_en     (jmp_en),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .br_target  (br_target),
        .prog_ctr   (pc),
        .absjump_en (absjump_en),
        .target     (target),
        .running    (running),
        .done       (done),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    always #5 clk = ~clk;

    // Program counter the sequencer steers: reset, redirect, or increment.
    always_ff @(posedge clk) begin
        if (reset)           pc <= '0;
        else if (absjump_en) pc <= target;
        else                 pc <= pc + 1'b1;
    end

    task automatic check(input string tag, input logic [D-1:0] got, input logic [D-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    always @(posedge clk) begin
        logic [D-1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pc", pc, e);
        end
    end

    task automatic go(input logic [7:0] f, input logic [D-1:0] tgt, input logic [D-1:0] exp_pc);
        {start, stall, halt_req, br_en, br_taken, jmp_en, call_en, ret_en} = f;
        br_target = tgt;
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {start, stall, halt_req, br_en, br_taken, jmp_en, call_en, ret_en} = 8'h00;
        br_target = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_absjump", 10'(absjump_en), 10'd0);
        check("reset_target", target, 10'd0);
        reset = 1'b0;
        #1;
        check("idle_running", 10'(running), 10'd0);
        check("idle_done", 10'(done), 10'd0);
        check("idle_flags", 10'({ras_ovf, ras_unf}), 10'd0);
        check("idle_hold", 10'(absjump_en), 10'd1);

        // Start holds PC for one cycle, then the PC increments.
        go(F_START, 10'h000, 10'h000);
        check("run_after_start", 10'(running), 10'd1);
        go(8'h00, 10'h000, 10'h001);
        go(8'h00, 10'h000, 10'h002);
        go(8'h00, 10'h000, 10'h003);

        // Conditional branch taken / not taken.
        go(F_BR | F_TAKEN, 10'h080, 10'h080);
        go(F_JMP, 10'h003, 10'h003);
        go(F_BR, 10'h080, 10'h004);

        // Nested call/return; the last call is immediately followed by a ret
        // that also carries a call request (ret wins).
        go(F_JMP, 10'd10, 10'd10);
        go(F_CALL, 10'h100, 10'h100);
        go(8'h00, 10'h000, 10'h101);
        go(8'h00, 10'h000, 10'h102);
        go(F_CALL, 10'h200, 10'h200);
        go(F_RET | F_CALL, 10'h3AA, 10'h103);
        go(F_RET, 10'h000, 10'd11);
        check("chain_flags", 10'({ras_ovf, ras_unf}), 10'd0);

        // Return address of a call at the top of the address space wraps to 0.
        go(F_JMP, 10'h3FF, 10'h3FF);
        go(F_CALL, 10'h005, 10'h005);
        go(F_RET, 10'h000, 10'h000);

        // Five nested calls overflow a 4-deep stack; oldest entry is lost.
        go(F_JMP, 10'h010, 10'h010);
        go(F_CALL, 10'h020, 10'h020);
        go(F_CALL, 10'h030, 10'h030);
        go(F_CALL, 10'h040, 10'h040);
        go(F_CALL, 10'h050, 10'h050);
        check("ovf_at_full", 10'(ras_ovf), 10'd0);
        go(F_CALL, 10'h060, 10'h060);
        check("ovf_set", 10'(ras_ovf), 10'd1);
        go(F_RET, 10'h000, 10'h051);
        go(F_RET, 10'h000, 10'h041);
        go(F_RET, 10'h000, 10'h031);
        go(F_RET, 10'h000, 10'h021);
        check("unf_before", 10'(ras_unf), 10'd0);
        go(F_RET, 10'h000, 10'h021);
        check("unf_set", 10'(ras_unf), 10'd1);
        check("unf_done", 10'(done), 10'd1);
        check("unf_running", 10'(running), 10'd0);
        go(8'h00, 10'h000, 10'h021);
        check("ovf_sticky", 10'(ras_ovf), 10'd1);

        // Restart from HALT jumps to 0 and clears the flags.
        go(F_START, 10'h000, 10'h000);
        check("restart_flags", 10'({ras_ovf, ras_unf}), 10'd0);
        check("restart_running", 10'(running), 10'd1);
        check("restart_done", 10'(done), 10'd0);

        // A stalled call has no effect; the stack must hold only one entry.
        go(F_JMP, 10'h007, 10'h007);
        go(F_STALL | F_CALL, 10'h150, 10'h007);
        go(F_CALL, 10'h150, 10'h150);
        go(F_RET, 10'h000, 10'h008);
        go(F_RET, 10'h000, 10'h008);
        check("stall_unf", 10'(ras_unf), 10'd1);
        check("stall_done", 10'(done), 10'd1);
        go(F_START, 10'h000, 10'h000);

        // Halt request freezes the PC until start.
        go(F_JMP, 10'd20, 10'd20);
        go(F_HALT, 10'h000, 10'd20);
        check("halt_done", 10'(done), 10'd1);
        check("halt_running", 10'(running), 10'd0);
        go(8'h00, 10'h000, 10'd20);
        go(F_START, 10'h000, 10'h000);
        check("halt_restart", 10'(running), 10'd1);

        // Reset mid-RUN discards the pushed return address.
        go(F_CALL, 10'h090, 10'h090);
        {start, stall, halt_req, br_en, br_taken, jmp_en, call_en, ret_en} = 8'h00;
        reset = 1'b1;
        #1;
        check("midreset_absjump", 10'(absjump_en), 10'd0);
        check("midreset_target", target, 10'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_idle", 10'(running), 10'd0);
        check("midreset_pc", pc, 10'd0);
        go(F_START, 10'h000, 10'h000);
        go(F_RET, 10'h000, 10'h000);
        check("midreset_empty", 10'(ras_unf), 10'd1);
        check("midreset_done", 10'(done), 10'd1);

        @(posedge clk);
        #3;
        check("queue_drained", 10'(exp_q.size()), 10'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
